setting_mode_editor: RTL

Consumer and return path for the setting-mode entry pulse (setting_mode_toggle) produced by the setting-mode controller.
- Once entered, walks the user through selecting and editing three hood settings: work-time limit, light-off delay and clean-reminder interval.
- Holds the committed values.
- Issues a one-cycle exit request (setting_exit_toggle) back to the mode FSM on user exit or inactivity timeout.
- Sits beside setting_mode_controller_top, between the debounced key layer and the mode FSM.

---
 rtl/setting_mode_editor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/setting_mode_editor.sv
// setting_mode_editor: select/edit/commit of hood settings with timeout exit.
// Optional SETTING_SAVE_ON_TIMEOUT_EN: an edit timeout commits edit_value.
module setting_mode_editor #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int WORK_MIN       = 1,
  parameter int WORK_MAX       = 24,
  parameter int WORK_DEF       = 8,
  parameter int LIGHT_MIN      = 0,
  parameter int LIGHT_MAX      = 60,
  parameter int LIGHT_DEF      = 5,
  parameter int CLEAN_MIN      = 10,
  parameter int CLEAN_MAX      = 200,
  parameter int CLEAN_DEF      = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setting_mode_toggle,
  input  logic       toggle_signal,
  input  logic       key_next,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_confirm,
  output logic       in_setting,
  output logic       setting_exit_toggle,
  output logic [1:0] sel_item,
  output logic [7:0] edit_value,
  output logic       commit_pulse,
  output logic [7:0] work_limit_hr,
  output logic [7:0] light_delay_min,
  output logic [7:0] clean_remind_hr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] W_MIN = 8'(WORK_MIN);
  localparam logic [7:0] W_MAX = 8'(WORK_MAX);
  localparam logic [7:0] W_DEF = 8'(WORK_DEF);
  localparam logic [7:0] L_MIN = 8'(LIGHT_MIN);
  localparam logic [7:0] L_MAX = 8'(LIGHT_MAX);
  localparam logic [7:0] L_DEF = 8'(LIGHT_DEF);
  localparam logic [7:0] C_MIN = 8'(CLEAN_MIN);
  localparam logic [7:0] C_MAX = 8'(CLEAN_MAX);
  localparam logic [7:0] C_DEF = 8'(CLEAN_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_EDIT,
    S_EXIT
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [1:0]    sel_d;
  logic [7:0]    ev_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [7:0]    work_d;
  logic [7:0]    light_d;
  logic [7:0]    clean_d;
  logic          commit_d;

  logic [7:0]    cur_min;
  logic [7:0]    cur_max;
  logic [7:0]    cur_val;
  logic [7:0]    ev_inc;
  logic [7:0]    ev_dec;
  logic [1:0]    sel_nxt;
  logic          any_key;
  logic          timeout;

  // Bounds and committed value of the currently selected item.
  always_comb begin
    cur_min = W_MIN;
    cur_max = W_MAX;
    cur_val = work_limit_hr;
    case (sel_item)
      2'd1: begin
        cur_min = L_MIN;
        cur_max = L_MAX;
        cur_val = light_delay_min;
      end
      2'd2: begin
        cur_min = C_MIN;
        cur_max = C_MAX;
        cur_val = clean_remind_hr;
      end
      default: ;
    endcase
  end

  assign ev_inc  = (edit_value >= cur_max) ? cur_min
                                           : edit_value + 8'd1;
  assign ev_dec  = (edit_value <= cur_min) ? cur_max
                                           : edit_value - 8'd1;
  assign sel_nxt = (sel_item == 2'd2) ? 2'd0 : sel_item + 2'd1;
  assign any_key = toggle_signal | key_confirm | key_next
                 | key_up | key_down;
  assign timeout = (cnt_q == TO_LAST) && !any_key;

  // Next state, selection, edit value, counter and commit decision.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_item;
    ev_d     = edit_value;
    cnt_d    = cnt_q;
    work_d   = work_limit_hr;
    light_d  = light_delay_min;
    clean_d  = clean_remind_hr;
    commit_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (setting_mode_toggle) begin
          state_d = S_SELECT;
          sel_d   = 2'd0;
        end
      end
      S_SELECT: begin
        cnt_d = any_key ? '0 : cnt_q + 1'b1;
        if (toggle_signal) begin
          state_d = S_EXIT;
        end else if (key_confirm) begin
          state_d = S_EDIT;
          ev_d    = cur_val;
        end else if (key_next) begin
          sel_d = sel_nxt;
        end else if (timeout) begin
          state_d = S_EXIT;
        end
      end
      S_EDIT: begin
        cnt_d = any_key ? '0 : cnt_q + 1'b1;
        if (toggle_signal) begin
          state_d = S_SELECT;
        end else if (key_confirm) begin
          state_d  = S_SELECT;
          commit_d = 1'b1;
        end else if (key_next) begin
          state_d = S_EDIT;
        end else if (key_up && !key_down) begin
          ev_d = ev_inc;
        end else if (key_down && !key_up) begin
          ev_d = ev_dec;
        end else if (timeout) begin
          state_d = S_EXIT;
`ifdef SETTING_SAVE_ON_TIMEOUT_EN
          commit_d = 1'b1;
`endif
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    if (commit_d) begin
      case (sel_item)
        2'd1:    light_d = edit_value;
        2'd2:    clean_d = edit_value;
        default: work_d  = edit_value;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= S_IDLE;
      cnt_q               <= '0;
      in_setting          <= 1'b0;
      setting_exit_toggle <= 1'b0;
      commit_pulse        <= 1'b0;
      sel_item            <= 2'd0;
      edit_value          <= 8'd0;
      work_limit_hr       <= W_DEF;
      light_delay_min     <= L_DEF;
      clean_remind_hr     <= C_DEF;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      in_setting          <= (state_d == S_SELECT)
                          || (state_d == S_EDIT);
      setting_exit_toggle <= (state_d == S_EXIT);
      commit_pulse        <= commit_d;
      sel_item            <= sel_d;
      edit_value          <= ev_d;
      work_limit_hr       <= work_d;
      light_delay_min     <= light_d;
      clean_remind_hr     <= clean_d;
    end
  end

endmodule
